// File: rtl/chartx_pkg.sv
// Shared types and elaboration-time helpers for the FSK character transmitter.
// Holds the frame-state enum, the tone phase-increment calculation and the triangle shaper.
package chartx_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PREAMBLE = 3'd1,
    START    = 3'd2,
    DATA     = 3'd3,
    STOP     = 3'd4
  } chartx_state_e;

  // Rounded freq * 2^width / clk_freq, evaluated at elaboration.
  function automatic longint phase_inc(input longint freq, input longint clk_freq,
                                       input int width);
    return ((freq << width) + (clk_freq / 2)) / clk_freq;
  endfunction

  // Maps the top phase bits onto a symmetric triangle spanning -128..127.
  function automatic logic signed [7:0] tri_wave(input logic msb, input logic [6:0] u);
    logic [7:0] u2;
    logic [7:0] res;
    u2  = {u, 1'b0};
    res = msb ? (8'd127 - u2) : (8'h80 + u2);
    return signed'(res);
  endfunction

endpackage

// File: rtl/fsk_nco.sv
// Two-tone phase accumulator with registered triangle output; one cycle from phase to sample.
// No backpressure; clears to phase 0 and output 0 whenever run is low.
module fsk_nco
  import chartx_pkg::*;
#(
  parameter int                 PHASE_W = 24,
  parameter logic [PHASE_W-1:0] INC0    = '0,
  parameter logic [PHASE_W-1:0] INC1    = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              bit_sel,
  output logic signed [7:0] sample
);

  logic [PHASE_W-1:0] phase;
  logic [PHASE_W-1:0] step;

  assign step = bit_sel ? INC1 : INC0;

  // The sample reflects the phase before this edge's increment, so a fresh run starts at -128.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase  <= '0;
      sample <= '0;
    end else if (!run) begin
      phase  <= '0;
      sample <= '0;
    end else begin
      sample <= tri_wave(phase[PHASE_W-1], phase[PHASE_W-2 -: 7]);
      phase  <= phase + step;
    end
  end

endmodule

// File: rtl/char_fsk_tx.sv
// Frames an 8-bit character as preamble/start/data/stop and drives a continuous-phase FSK DAC stream.
// Accept-to-first-sample is one cycle; char_ready is low for the whole frame, so the sender is held off.
module char_fsk_tx
  import chartx_pkg::*;
#(
  parameter int SYS_CLK_FREQ = 1_600_000,
  parameter int SYMBOL_RATE  = 100,
  parameter int F0_FREQ      = 7_200,
  parameter int F1_FREQ      = 8_800,
  parameter int PREAMBLE_LEN = 8,
  parameter int PHASE_W      = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [7:0]        char_in,
  input  logic              char_valid,
  output logic              char_ready,
  output logic signed [7:0] dac_out,
  output logic              tx_active,
  output logic              tx_bit
);

  localparam int CPS  = SYS_CLK_FREQ / SYMBOL_RATE;
  localparam int SCW  = (CPS > 1) ? $clog2(CPS) : 1;
  localparam int BMAX = (PREAMBLE_LEN > 8) ? PREAMBLE_LEN : 8;
  localparam int BCW  = $clog2(BMAX + 1);

  localparam logic [PHASE_W-1:0] INC0 =
    PHASE_W'(phase_inc(longint'(F0_FREQ), longint'(SYS_CLK_FREQ), PHASE_W));
  localparam logic [PHASE_W-1:0] INC1 =
    PHASE_W'(phase_inc(longint'(F1_FREQ), longint'(SYS_CLK_FREQ), PHASE_W));

  if (SYS_CLK_FREQ % SYMBOL_RATE != 0) begin : g_bad_rate
    $error("SYS_CLK_FREQ must be a multiple of SYMBOL_RATE");
  end
  if (CPS < 2) begin : g_bad_cps
    $error("a symbol must span at least two clocks");
  end
  if (PREAMBLE_LEN < 1) begin : g_bad_preamble
    $error("PREAMBLE_LEN must be at least 1");
  end
  if (PHASE_W < 8) begin : g_bad_phase_w
    $error("PHASE_W must be at least 8");
  end

  chartx_state_e  state, state_nxt;
  logic [SCW-1:0] sym_cnt, sym_nxt;
  logic [BCW-1:0] bit_cnt, bit_nxt;
  logic [7:0]     shreg, shreg_nxt;
  logic           bit_sel;
  logic           sym_wrap;
  logic           accept;
  logic           nco_run;

  assign char_ready = en && (state == IDLE) && !rst;
  assign accept     = char_valid && char_ready;
  assign sym_wrap   = (sym_cnt == SCW'(CPS - 1));
  assign tx_active  = (state != IDLE);

  always_comb begin
    state_nxt = state;
    sym_nxt   = sym_cnt;
    bit_nxt   = bit_cnt;
    shreg_nxt = shreg;
    if (state == IDLE) begin
      sym_nxt = '0;
      bit_nxt = '0;
      if (accept) begin
        state_nxt = PREAMBLE;
        shreg_nxt = char_in;
      end
    end else if (!sym_wrap) begin
      sym_nxt = sym_cnt + SCW'(1);
    end else begin
      sym_nxt = '0;
      case (state)
        PREAMBLE: begin
          if (bit_cnt == BCW'(PREAMBLE_LEN - 1)) begin
            state_nxt = START;
            bit_nxt   = '0;
          end else begin
            bit_nxt = bit_cnt + BCW'(1);
          end
        end
        START: begin
          state_nxt = DATA;
          bit_nxt   = '0;
        end
        DATA: begin
          shreg_nxt = {1'b0, shreg[7:1]};
          if (bit_cnt == BCW'(7)) begin
            state_nxt = STOP;
            bit_nxt   = '0;
          end else begin
            bit_nxt = bit_cnt + BCW'(1);
          end
        end
        STOP:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Bit of the symbol that will be on air after this edge; the NCO steps with it in lockstep.
  always_comb begin
    bit_sel = 1'b0;
    case (state_nxt)
      PREAMBLE: bit_sel = ~bit_nxt[0];
      START:    bit_sel = 1'b0;
      DATA:     bit_sel = shreg_nxt[0];
      STOP:     bit_sel = 1'b1;
      default:  bit_sel = 1'b0;
    endcase
  end

  assign nco_run = (state_nxt != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      sym_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      tx_bit  <= 1'b0;
    end else begin
      state   <= state_nxt;
      sym_cnt <= sym_nxt;
      bit_cnt <= bit_nxt;
      shreg   <= shreg_nxt;
      tx_bit  <= bit_sel;
    end
  end

  fsk_nco #(
    .PHASE_W (PHASE_W),
    .INC0    (INC0),
    .INC1    (INC1)
  ) u_nco (
    .clk     (clk),
    .rst     (rst),
    .run     (nco_run),
    .bit_sel (bit_sel),
    .sample  (dac_out)
  );

endmodule

// File: tb/tb_char_fsk_tx.sv
// Directed bench for char_fsk_tx with the symbol rate raised so a frame lasts 2880 clocks.
// Tone/clock ratio is kept at the default, so the increments are the stock 75497 / 92275.
module tb_char_fsk_tx;

  localparam int SYS   = 1_600_000;
  localparam int SR    = 10_000;
  localparam int PL    = 8;
  localparam int CPS   = 160;
  localparam int FRAME = (PL + 10) * CPS;
  localparam int INC0  = 75497;
  localparam int INC1  = 92275;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              en = 1'b1;
  logic [7:0]        char_in = 8'h00;
  logic              char_valid = 1'b0;
  logic              char_ready;
  logic signed [7:0] dac_out;
  logic              tx_active;
  logic              tx_bit;

  int     n_cmp = 0;
  int     n_bad = 0;
  longint cyc = 0;
  longint acc_q[$];

  char_fsk_tx #(
    .SYS_CLK_FREQ (SYS),
    .SYMBOL_RATE  (SR),
    .F0_FREQ      (7_200),
    .F1_FREQ      (8_800),
    .PREAMBLE_LEN (PL),
    .PHASE_W      (24)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .char_in    (char_in),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .dac_out    (dac_out),
    .tx_active  (tx_active),
    .tx_bit     (tx_bit)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst && char_valid && char_ready) acc_q.push_back(cyc);
  end

  task automatic chk(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int tri_ref(input logic [23:0] p);
    int u;
    u = int'(p[22:16]);
    return p[23] ? (127 - 2 * u) : (-128 + 2 * u);
  endfunction

  function automatic logic exp_bit(input logic [7:0] ch, input int s);
    if (s < PL) return (s % 2 == 0);
    if (s == PL) return 1'b0;
    if (s < PL + 9) return ch[s - PL - 1];
    return 1'b1;
  endfunction

  // Entered at the negedge just after the accepting edge; returns at the negedge of the first idle cycle.
  task automatic check_frame(input logic [7:0] ch, input string tag, input int en_drop,
                             output logic [17:0] seen);
    logic [23:0] p;
    int e_dac, e_bit, e_ctl, maxd, prev, d, s;
    p = '0; e_dac = 0; e_bit = 0; e_ctl = 0; maxd = 0; prev = 0;
    seen = '0;
    chk({tag, "_first_dac"}, int'(dac_out), -128);
    chk({tag, "_first_bit"}, tx_bit, 1);
    for (int j = 0; j < FRAME; j++) begin
      s = j / CPS;
      if (j == en_drop) en = 1'b0;
      if (int'(dac_out) != tri_ref(p)) e_dac++;
      if (tx_bit !== exp_bit(ch, s)) e_bit++;
      if (tx_active !== 1'b1 || char_ready !== 1'b0) e_ctl++;
      if (j > 0) begin
        d = int'(dac_out) - prev;
        if (d < 0) d = -d;
        if (d > maxd) maxd = d;
      end
      prev = int'(dac_out);
      if (j % CPS == CPS / 2) seen[s] = tx_bit;
      p = p + (exp_bit(ch, s) ? 24'(INC1) : 24'(INC0));
      @(negedge clk);
    end
    chk({tag, "_dac_errs"}, e_dac, 0);
    chk({tag, "_bit_errs"}, e_bit, 0);
    chk({tag, "_active_ready_errs"}, e_ctl, 0);
    chk({tag, "_max_step_le4"}, (maxd <= 4) ? 1 : 0, 1);
    chk({tag, "_end_active"}, tx_active, 0);
    chk({tag, "_end_dac"}, int'(dac_out), 0);
    chk({tag, "_end_bit"}, tx_bit, 0);
    chk({tag, "_end_ready"}, char_ready, en);
  endtask

  initial begin
    logic [17:0] seen;
    logic [17:0] exp41;
    int   bad;
    int   nacc;

    exp41 = 18'b101000001001010101;

    // Reset and idle behaviour.
    repeat (3) @(negedge clk);
    chk("rst_ready", char_ready, 0);
    chk("rst_dac", int'(dac_out), 0);
    chk("rst_active", tx_active, 0);
    rst = 1'b0;
    #1;
    chk("idle_ready", char_ready, 1);
    chk("idle_dac", int'(dac_out), 0);
    chk("idle_active", tx_active, 0);
    chk("idle_bit", tx_bit, 0);
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (char_ready !== 1'b1 || dac_out !== 8'sd0 || tx_active !== 1'b0 || tx_bit !== 1'b0) bad++;
    end
    chk("idle_1000_changes", bad, 0);
    en = 1'b0;
    #1 chk("idle_ready_en_low", char_ready, 0);
    en = 1'b1;
    #1 chk("idle_ready_en_high", char_ready, 1);

    // Single frame 0x41.
    @(negedge clk);
    char_in = 8'h41;
    char_valid = 1'b1;
    @(negedge clk);
    char_valid = 1'b0;
    check_frame(8'h41, "f41", -1, seen);
    chk("f41_bit_sequence", seen, exp41);

    // Back-to-back handshake with valid held high.
    acc_q.delete();
    char_in = 8'h55;
    char_valid = 1'b1;
    @(negedge clk);
    char_in = 8'hAA;
    check_frame(8'h55, "f55", -1, seen);
    @(negedge clk);
    check_frame(8'hAA, "faa", -1, seen);
    char_valid = 1'b0;
    chk("hs_accept_count", acc_q.size(), 2);
    chk("hs_accept_spacing", (acc_q.size() >= 2) ? (acc_q[1] - acc_q[0]) : -1, FRAME + 1);

    // en dropped at symbol 5: frame completes, then no accept until en returns.
    char_in = 8'h3C;
    char_valid = 1'b1;
    @(negedge clk);
    check_frame(8'h3C, "fen", 5 * CPS, seen);
    nacc = acc_q.size();
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (char_ready !== 1'b0 || tx_active !== 1'b0) bad++;
    end
    chk("en_low_hold", bad, 0);
    chk("en_low_no_accept", acc_q.size(), nacc);
    en = 1'b1;
    #1 chk("en_back_ready", char_ready, 1);
    @(negedge clk);
    chk("en_back_accept", acc_q.size(), nacc + 1);
    chk("en_back_active", tx_active, 1);
    chk("en_back_dac", int'(dac_out), -128);

    // Asynchronous reset in the middle of the data bits.
    repeat (12 * CPS + 37) @(negedge clk);
    chk("pre_rst_active", tx_active, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_dac", int'(dac_out), 0);
    chk("arst_active", tx_active, 0);
    chk("arst_bit", tx_bit, 0);
    chk("arst_ready", char_ready, 0);
    char_in = 8'h96;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("post_rst_ready", char_ready, 1);
    @(negedge clk);
    char_valid = 1'b0;
    check_frame(8'h96, "f96", -1, seen);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
